// File: rtl/usr_pkg.sv
// usr_pkg -- shared definitions for the usr_4bit command sequencer.
//
// Contents:
//   - command op-code constants (LOAD, SHR, SHL, ROR, ROL; 5..7 illegal)
//   - usr_4bit mode-select constants (HOLD/SHR/SHL/LOAD)
//   - sequencer state enum (IDLE/EXEC/DONE)
//   - op_legal(): decides whether an op code is executable in this build
//
// Configuration macro: USR_SEQ_ROTATE_EN
//   defined   -> ROR/ROL are legal and drive rotate feedback
//   undefined -> ROR/ROL are reported as illegal (done with err)
package usr_pkg;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // True when the op code can be executed by this build.
    function automatic logic op_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_LOAD, OP_SHR, OP_SHL: legal = 1'b1;
`ifdef USR_SEQ_ROTATE_EN
            OP_ROR, OP_ROL:          legal = 1'b1;
`endif
            default:                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/usr_4bit.sv
// usr_4bit -- 4-bit universal shift register.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears q)
//   s[1:0]     : 00 hold, 01 shift right (q[3] <- s_r_in),
//                10 shift left (q[0] <- s_l_in), 11 parallel load
//   s_r_in     : serial input entering at q[3] on shift right
//   s_l_in     : serial input entering at q[0] on shift left
//   p_in[3:0]  : parallel load data
//   q[3:0]     : register contents
module usr_4bit
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] s,
    input  logic       s_r_in,
    input  logic       s_l_in,
    input  logic [3:0] p_in,
    output logic [3:0] q
);

    // Register update according to the mode select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 4'b0000;
        end else begin
            case (s)
                USR_HOLD: q <= q;
                USR_SHR:  q <= {s_r_in, q[3:1]};
                USR_SHL:  q <= {q[2:0], s_l_in};
                USR_LOAD: q <= p_in;
                default:  q <= q;
            endcase
        end
    end

endmodule

// File: rtl/usr_seq_top.sv
// usr_seq_top -- sequencer plus the usr_4bit register it controls.
//
// Ports: clk, rst, the command handshake (cmd_*), ser_in, and the status
// outputs of usr_seq_ctrl, plus q (register contents).
// Configuration macro: USR_SEQ_ROTATE_EN (passed through to usr_seq_ctrl).
module usr_seq_top #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [3:0]       cmd_data,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_out_vld,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [3:0]       q
);

    logic [1:0] usr_s;
    logic       usr_s_r_in;
    logic       usr_s_l_in;
    logic [3:0] usr_p_in;

    usr_seq_ctrl #(.CNT_W(CNT_W)) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_cnt     (cmd_cnt),
        .cmd_data    (cmd_data),
        .ser_in      (ser_in),
        .usr_q       (q),
        .usr_s       (usr_s),
        .usr_s_r_in  (usr_s_r_in),
        .usr_s_l_in  (usr_s_l_in),
        .usr_p_in    (usr_p_in),
        .ser_out     (ser_out),
        .ser_out_vld (ser_out_vld),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    usr_4bit u_reg (
        .clk    (clk),
        .rst    (rst),
        .s      (usr_s),
        .s_r_in (usr_s_r_in),
        .s_l_in (usr_s_l_in),
        .p_in   (usr_p_in),
        .q      (q)
    );

endmodule

// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl -- command sequencer for one usr_4bit register.
//
// Accepts LOAD/SHR/SHL/ROR/ROL commands over a valid/ready handshake and
// drives the register's mode select and serial/parallel inputs for the
// requested number of cycles, then pulses done (qualified by err).
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_op, cmd_cnt     : op code, step count (count ignored for LOAD)
//   cmd_data            : parallel load value (ignored for non-LOAD ops)
//   ser_in              : serial fill bit for SHR/SHL
//   usr_q               : current register contents (rotate feedback, ser_out)
//   usr_s, usr_s_r_in, usr_s_l_in, usr_p_in : register controls
//   ser_out/ser_out_vld : bit leaving the register during shift/rotate
//   busy, done, err     : status
//
// Configuration macro: USR_SEQ_ROTATE_EN (enables ROR/ROL; otherwise illegal).
module usr_seq_ctrl
    import usr_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [3:0]       cmd_data,
    input  logic             ser_in,
    input  logic [3:0]       usr_q,
    output logic [1:0]       usr_s,
    output logic             usr_s_r_in,
    output logic             usr_s_l_in,
    output logic [3:0]       usr_p_in,
    output logic             ser_out,
    output logic             ser_out_vld,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    seq_state_t       state_r;
    seq_state_t       state_nxt;
    logic [2:0]       op_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       data_r;
    logic             err_r;
    logic             accept;
    logic             skip_exec;

    assign accept = cmd_valid && (state_r == IDLE);

    // Illegal ops and zero-length shifts bypass EXEC; LOAD always runs once.
    assign skip_exec = !op_legal(cmd_op) ||
                       ((cmd_op != OP_LOAD) && (cmd_cnt == CNT_ZERO));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Command latch and remaining-step counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r   <= OP_LOAD;
            cnt_r  <= CNT_ZERO;
            data_r <= 4'b0000;
            err_r  <= 1'b0;
        end else if (accept) begin
            op_r   <= cmd_op;
            cnt_r  <= (cmd_op == OP_LOAD) ? CNT_ONE : cmd_cnt;
            data_r <= cmd_data;
            err_r  <= !op_legal(cmd_op);
        end else if (state_r == EXEC) begin
            cnt_r  <= cnt_r - CNT_ONE;
        end else begin
            cnt_r  <= cnt_r;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = skip_exec ? DONE : EXEC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = EXEC;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; serial feedback must be same-cycle, so these follow
    // the registered state/command rather than being separately flopped.
    always_comb begin
        usr_s       = USR_HOLD;
        usr_s_r_in  = 1'b0;
        usr_s_l_in  = 1'b0;
        usr_p_in    = 4'b0000;
        ser_out     = 1'b0;
        ser_out_vld = 1'b0;
        if (state_r == EXEC) begin
            case (op_r)
                OP_LOAD: begin
                    usr_s    = USR_LOAD;
                    usr_p_in = data_r;
                end
                OP_SHR: begin
                    usr_s       = USR_SHR;
                    usr_s_r_in  = ser_in;
                    ser_out     = usr_q[0];
                    ser_out_vld = 1'b1;
                end
                OP_SHL: begin
                    usr_s       = USR_SHL;
                    usr_s_l_in  = ser_in;
                    ser_out     = usr_q[3];
                    ser_out_vld = 1'b1;
                end
`ifdef USR_SEQ_ROTATE_EN
                OP_ROR: begin
                    usr_s       = USR_SHR;
                    usr_s_r_in  = usr_q[0];
                    ser_out     = usr_q[0];
                    ser_out_vld = 1'b1;
                end
                OP_ROL: begin
                    usr_s       = USR_SHL;
                    usr_s_l_in  = usr_q[3];
                    ser_out     = usr_q[3];
                    ser_out_vld = 1'b1;
                end
`endif
                default: begin
                    usr_s = USR_HOLD;
                end
            endcase
        end else begin
            usr_s = USR_HOLD;
        end
    end

    assign cmd_ready = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign done      = (state_r == DONE);
    assign err       = (state_r == DONE) && err_r;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// tb_usr_seq_ctrl -- directed bench for usr_seq_ctrl driving a usr_4bit.
// Expected values are hand-computed constants. Honours USR_SEQ_ROTATE_EN.
module tb_usr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_cnt;
    logic [3:0] cmd_data;
    logic       ser_in;
    logic [3:0] usr_q;
    logic [1:0] usr_s;
    logic       usr_s_r_in;
    logic       usr_s_l_in;
    logic [3:0] usr_p_in;
    logic       ser_out;
    logic       ser_out_vld;
    logic       busy;
    logic       done;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    usr_seq_ctrl #(.CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_cnt     (cmd_cnt),
        .cmd_data    (cmd_data),
        .ser_in      (ser_in),
        .usr_q       (usr_q),
        .usr_s       (usr_s),
        .usr_s_r_in  (usr_s_r_in),
        .usr_s_l_in  (usr_s_l_in),
        .usr_p_in    (usr_p_in),
        .ser_out     (ser_out),
        .ser_out_vld (ser_out_vld),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    usr_4bit u_reg (
        .clk    (clk),
        .rst    (rst),
        .s      (usr_s),
        .s_r_in (usr_s_r_in),
        .s_l_in (usr_s_l_in),
        .p_in   (usr_p_in),
        .q      (usr_q)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command and return just after the acceptance edge.
    task automatic send(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data);
        int waited;
        @(negedge clk);
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = data;
        cmd_valid = 1'b1;
        waited    = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) chk("send_timeout", 8'd0, 8'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        // Scramble the bus to show the latched command is held.
        cmd_op    = 3'd7;
        cmd_cnt   = 3'd7;
        cmd_data  = ~data;
    endtask

    // Latency in cycles from acceptance edge to the edge sampling done.
    task automatic wait_done(output int lat, output logic e, output logic [3:0] q);
        lat = 1;
        e   = 1'b0;
        q   = 4'b0000;
        while (lat < 40) begin
            @(negedge clk);
            if (done) break;
            lat++;
        end
        if (!done) chk("done_timeout", 8'd0, 8'd1);
        e = err;
        q = usr_q;
    endtask

    int         lat;
    logic       e;
    logic [3:0] q;
    int         pulses;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_cnt = 3'd0;
        cmd_data = 4'd0; ser_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
        chk("rst_s",     {6'd0, usr_s},     8'd0);
        chk("rst_q",     {4'd0, usr_q},     8'd0);
        chk("rst_stat",  {5'd0, busy, done, err}, 8'd0);
        chk("rst_ser",   {4'd0, usr_s_r_in, usr_s_l_in, ser_out_vld, |usr_p_in}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // LOAD 1011
        send(3'd0, 3'd3, 4'b1011);
        wait_done(lat, e, q);
        chk("load_lat", lat[7:0], 8'd2);
        chk("load_q",   {4'd0, q}, 8'hB);
        chk("load_err", {7'd0, e}, 8'd0);

        // SHR cnt=2, ser_in=1 : 1011 -> 1101 -> 1110, ser_out 1,1
        ser_in = 1'b1;
        send(3'd1, 3'd2, 4'b0000);
        @(negedge clk);
        chk("shr_c0", {ser_out_vld, ser_out, usr_s, usr_q}, 8'b1_1_01_1011);
        @(negedge clk);
        chk("shr_c1", {ser_out_vld, ser_out, usr_s, usr_q}, 8'b1_1_01_1101);
        @(negedge clk);
        chk("shr_done", {done, err, ser_out_vld, 1'b0, usr_q}, 8'b1_0_0_0_1110);

        // SHL cnt=1, ser_in=0 : 1110 -> 1100, ser_out 1
        ser_in = 1'b0;
        send(3'd2, 3'd1, 4'b1111);
        @(negedge clk);
        chk("shl_c0", {ser_out_vld, ser_out, usr_s, usr_q}, 8'b1_1_10_1110);
        @(posedge clk);
        wait_done(lat, e, q);
        chk("shl_q", {4'd0, q}, 8'b0000_1100);

        // Rotates from 1011
        send(3'd0, 3'd0, 4'b1011);
        wait_done(lat, e, q);
`ifdef USR_SEQ_ROTATE_EN
        send(3'd3, 3'd1, 4'b0000);
        wait_done(lat, e, q);
        chk("ror1", {lat[3:0], q}, {4'd2, 4'b1101});
        send(3'd0, 3'd0, 4'b1011);
        wait_done(lat, e, q);
        send(3'd3, 3'd4, 4'b0000);
        wait_done(lat, e, q);
        chk("ror4", {lat[3:0], q}, {4'd5, 4'b1011});
        send(3'd4, 3'd1, 4'b0000);
        wait_done(lat, e, q);
        chk("rol1", {3'd0, e, q}, {4'd0, 4'b0111});
        send(3'd0, 3'd0, 4'b1011);
        wait_done(lat, e, q);
`else
        send(3'd3, 3'd1, 4'b0000);
        wait_done(lat, e, q);
        chk("ror_ill", {lat[2:0], e, q}, {3'd1, 1'b1, 4'b1011});
        send(3'd4, 3'd2, 4'b0000);
        wait_done(lat, e, q);
        chk("rol_ill", {lat[2:0], e, q}, {3'd1, 1'b1, 4'b1011});
`endif

        // Illegal op 7, then SHR cnt=0
        send(3'd7, 3'd3, 4'b0000);
        wait_done(lat, e, q);
        chk("op7", {lat[2:0], e, q}, {3'd1, 1'b1, 4'b1011});
        send(3'd1, 3'd0, 4'b0000);
        wait_done(lat, e, q);
        chk("cnt0", {lat[2:0], e, q}, {3'd1, 1'b0, 4'b1011});

        // cmd_valid held through busy: SHL cnt=1 ser_in=1 from 0110
        send(3'd0, 3'd0, 4'b0110);
        wait_done(lat, e, q);
        @(negedge clk);
        ser_in = 1'b1; cmd_op = 3'd2; cmd_cnt = 3'd1; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_c0", {6'd0, cmd_ready, busy}, 8'b01);
        @(negedge clk);
        chk("hold_c1", {5'd0, cmd_ready, busy, done}, 8'b011);
        @(negedge clk);
        chk("hold_c2", {6'd0, cmd_ready, busy}, 8'b10);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("hold_c3", {6'd0, cmd_ready, busy}, 8'b01);
        wait_done(lat, e, q);
        chk("hold_q", {4'd0, q}, 8'b0000_1011);

        // Reset in the 2nd EXEC cycle of SHR cnt=5
        send(3'd1, 3'd5, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst", {cmd_ready, busy, done, err, usr_q}, 8'b1000_0000);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("mid_rst_nodone", pulses[7:0], 8'd0);
        chk("mid_rst_idle", {6'd0, cmd_ready, busy}, 8'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
